sm_mcu_lcd_pio: RTL and testbench
=================================

Name: sm_mcu_lcd_pio

Overview:
- Parametrised Avalon-MM output PIO for the SM_MCU LCD control and data pins (RS, WR, RD, CS, data bus).
- Generalises the single-bit LCD output ports in three ways:
  - width set by parameter;
  - atomic bit set and clear registers;
  - a hardware-timed pulse engine, so firmware can issue WR/RD strobes of exact cycle length without busy-waiting.
- Sits on the Nios/MCU Avalon fabric; out_port drives the TFT pins directly.

Parameters:
- DATA_WIDTH, 8, number of output bits (1..32).
- CNT_WIDTH, 16, width of the pulse length counter (1..32).
- RESET_VALUE, 0, reset value of the DATA register.
- PULSE_LEN_RESET, 4, reset value of the PULSE_LEN register.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, read latency 0, no waitrequest.
- out_port  out  DATA_WIDTH  pin outputs.
- busy  out  1  high while a pulse is active.

Behaviour:
- Register map:
  - 0 DATA: rw.
  - 1 PULSE_LEN: rw, low CNT_WIDTH bits.
  - 2 STATUS: bit0 busy (ro), bit1 overrun (sticky). Any write to STATUS clears overrun.
  - 3 reserved: reads 0.
  - 4 OUTSET: wo, DATA |= writedata.
  - 5 OUTCLR: wo, DATA &= ~writedata.
  - 6 PULSE: wo, starts a pulse with mask = writedata.
  - 7 reserved: reads 0.
- Write-only and reserved addresses read 0. Unused upper bits read 0; writes to them are ignored.
- A write is chipselect & ~write_n. It is sampled on the clk edge; the register changes on that edge, so out_port reflects it from the next cycle.
- out_port = DATA ^ (busy ? pulse_mask : 0). Both operands are registers, so out_port is glitch-free with no combinational path from bus inputs.
- Pulse FSM states are IDLE and ACTIVE.
- IDLE + PULSE write:
  - pulse_mask <= writedata[DATA_WIDTH-1:0];
  - cnt <= max(PULSE_LEN, 1);
  - go to ACTIVE.
- ACTIVE:
  - cnt decrements each cycle;
  - when cnt == 1 and no new PULSE write, clear pulse_mask and return to IDLE.
  - The masked bits are therefore inverted for exactly max(PULSE_LEN, 1) cycles.
- PULSE_LEN = 0 is treated as 1.
- PULSE write in ACTIVE with cnt > 1: the write is ignored and overrun <= 1.
- PULSE write in ACTIVE with cnt == 1: the write is accepted back-to-back. The new mask and count load with no idle cycle, and overrun is not set.
- A pulse mask of 0 still runs the FSM; busy is asserted with no pin change.
- DATA, OUTSET and OUTCLR writes during ACTIVE update DATA immediately. Masked bits show the inverted new DATA value.
- A PULSE_LEN write during ACTIVE affects only the next pulse.
- Reset values:
  - DATA = RESET_VALUE;
  - PULSE_LEN = PULSE_LEN_RESET;
  - pulse_mask = 0, cnt = 0, state IDLE, overrun = 0;
  - busy = 0, out_port = RESET_VALUE.
- reset_n asserted mid-pulse aborts it immediately (asynchronous). out_port returns to RESET_VALUE.
- busy output is the same signal as STATUS bit0.

Decomposition:
- Shared package sm_mcu_pio_pkg holds:
  - register address constants (ADDR_DATA … ADDR_PULSE);
  - STATUS bit indices;
  - FSM state encoding (IDLE = 0, ACTIVE = 1).
- One natural sub-module, sm_mcu_pulse_timer, containing the counter, FSM and overrun logic. Its interface is start, len, mask in; busy, active mask, overrun out.
- The register file and read mux stay in the top level.

Test Plan:
- Reset with DATA_WIDTH = 8, RESET_VALUE = 8'hA5 -> out_port = 8'hA5, busy = 0; read addr 1 = 4, read addr 2 = 0.
- Write DATA = 8'h0F, then OUTSET 8'h30, then OUTCLR 8'h01 -> out_port goes 0F, 3F, 3E, each one cycle after its write; read addr 0 = 32'h3E; reads of addr 4/5/6 = 0.
- PULSE_LEN = 3, DATA = 0, PULSE 8'h02 -> out_port = 8'h02 for exactly 3 cycles and busy high for the same 3 cycles, then 0.
- PULSE_LEN = 0, PULSE 8'h80 -> one-cycle pulse. Next, PULSE_LEN = 5, PULSE 8'h01, then a second PULSE at cnt == 3 -> ignored, STATUS = 3. Write STATUS -> overrun clears.
- PULSE_LEN = 2: PULSE 8'h04, then PULSE 8'h08 in the cycle where cnt == 1 -> bit2 high for 2 cycles, then bit3 high for 2 cycles with no gap; overrun = 0.
- PULSE_LEN = 10, PULSE 8'hFF, then assert reset_n low at cycle 4 -> out_port = RESET_VALUE and busy = 0 immediately; after release, FSM is IDLE and PULSE_LEN = 4.

Source files
------------

// File: rtl/sm_mcu_pio_pkg.sv
// Shared constants for the SM_MCU LCD output PIO: register map, STATUS bits, pulse FSM states.
package sm_mcu_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_STATUS    = 3'd2;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR    = 3'd5;
    localparam logic [2:0] ADDR_PULSE     = 3'd6;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_OVERRUN = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/sm_mcu_pulse_timer.sv
// Hardware-timed pulse engine: inverts a mask of pins for max(len,1) cycles,
// accepts a back-to-back start on the final cycle, flags early starts as overrun.
module sm_mcu_pulse_timer
    import sm_mcu_pio_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clr_overrun,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] mask,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] active_mask,
    output logic                  overrun
);

    pulse_state_e          state, state_nx;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] mask_q, mask_nx;
    logic                  ovr_q, ovr_nx;
    logic [CNT_WIDTH-1:0]  load_len;
    logic                  last;

    // A zero length still produces a one-cycle pulse.
    assign load_len = (len == '0) ? CNT_WIDTH'(1) : len;
    assign last     = (cnt == CNT_WIDTH'(1));

    // State, counter, mask and overrun registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mask_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            mask_q <= mask_nx;
            ovr_q  <= ovr_nx;
        end
    end

    // Next-state logic: load on start, count down, reload or retire on the last cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mask_nx  = mask_q;
        ovr_nx   = ovr_q & ~clr_overrun;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ACTIVE;
                    cnt_nx   = load_len;
                    mask_nx  = mask;
                end
            end
            ACTIVE: begin
                if (last) begin
                    if (start) begin
                        cnt_nx  = load_len;
                        mask_nx = mask;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        mask_nx  = '0;
                    end
                end else begin
                    cnt_nx = cnt - CNT_WIDTH'(1);
                    if (start) ovr_nx = 1'b1;
                end
            end
        endcase
    end

    assign busy        = (state == ACTIVE);
    assign active_mask = mask_q;
    assign overrun     = ovr_q;

endmodule

// File: rtl/sm_mcu_lcd_pio.sv
// Avalon-MM output PIO for the LCD control/data pins with set/clear registers and a timed pulse engine.
module sm_mcu_lcd_pio
    import sm_mcu_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    CNT_WIDTH       = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
    parameter logic [CNT_WIDTH-1:0]  PULSE_LEN_RESET = CNT_WIDTH'(4)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0]  pulse_len;
    logic [DATA_WIDTH-1:0] active_mask;
    logic                  overrun;
    logic                  wr;
    logic                  unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // DATA register: direct write plus atomic set/clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data <= writedata[DATA_WIDTH-1:0];
                ADDR_OUTSET: data <= data | writedata[DATA_WIDTH-1:0];
                ADDR_OUTCLR: data <= data & ~writedata[DATA_WIDTH-1:0];
                default:     data <= data;
            endcase
        end
    end

    // PULSE_LEN register; only the next pulse picks up a new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_len <= PULSE_LEN_RESET;
        end else if (wr && address == ADDR_PULSE_LEN) begin
            pulse_len <= writedata[CNT_WIDTH-1:0];
        end
    end

    sm_mcu_pulse_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (wr && address == ADDR_PULSE),
        .clr_overrun (wr && address == ADDR_STATUS),
        .len         (pulse_len),
        .mask        (writedata[DATA_WIDTH-1:0]),
        .busy        (busy),
        .active_mask (active_mask),
        .overrun     (overrun)
    );

    // Both operands are registers, so the pins never see bus-input glitches.
    assign out_port = data ^ (busy ? active_mask : '0);

    // Zero-latency read mux; write-only and reserved addresses read 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata[DATA_WIDTH-1:0] = data;
            ADDR_PULSE_LEN: readdata[CNT_WIDTH-1:0]  = pulse_len;
            ADDR_STATUS: begin
                readdata[STATUS_BUSY]    = busy;
                readdata[STATUS_OVERRUN] = overrun;
            end
            default:        readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sm_mcu_lcd_pio.sv
// Bench for sm_mcu_lcd_pio: time-based pulse model, per-cycle compare, directed literal checks, random traffic.
module tb_sm_mcu_lcd_pio;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        busy;

    always #5 clk = ~clk;

    sm_mcu_lcd_pio #(
        .DATA_WIDTH      (8),
        .CNT_WIDTH       (16),
        .RESET_VALUE     (RV),
        .PULSE_LEN_RESET (16'd4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    // Model: k counts clock edges; a pulse accepted at edge k is visible
    // after edges k .. k+len-1, i.e. busy after edge j iff j < m_end.
    int          k = 0;
    int          m_end = 0;
    logic [7:0]  m_data = RV;
    logic [7:0]  m_mask = 8'h00;
    logic [15:0] m_len = 16'd4;
    logic        m_ovr = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k = 0; m_end = 0; m_data = RV; m_mask = 8'h00; m_len = 16'd4; m_ovr = 1'b0;
        end else begin
            k = k + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: m_len = writedata[15:0];
                    3'd2: m_ovr = 1'b0;
                    3'd4: m_data = m_data | writedata[7:0];
                    3'd5: m_data = m_data & ~writedata[7:0];
                    3'd6: begin
                        if (k >= m_end) begin
                            m_end  = k + ((m_len == 16'd0) ? 1 : int'(m_len));
                            m_mask = writedata[7:0];
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Literal expectations posted by the directed sequence.
    logic        l_en = 1'b0;
    logic        l_rd_en = 1'b0;
    logic [7:0]  l_out = 8'h00;
    logic        l_busy = 1'b0;
    logic [31:0] l_rd = 32'd0;
    string       l_name = "";

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, got, exp, $time);
        end
    endtask

    // Single compare process: model every cycle, plus any posted literal.
    always @(negedge clk) begin
        logic        bexp;
        logic [7:0]  oexp;
        logic [31:0] rexp;
        bexp = (k < m_end);
        oexp = m_data ^ (bexp ? m_mask : 8'h00);
        case (address)
            3'd0:    rexp = {24'd0, m_data};
            3'd1:    rexp = {16'd0, m_len};
            3'd2:    rexp = {30'd0, m_ovr, bexp};
            default: rexp = 32'd0;
        endcase
        chk("model_out_port", {24'd0, out_port}, {24'd0, oexp});
        chk("model_busy", {31'd0, busy}, {31'd0, bexp});
        chk("model_readdata", readdata, rexp);
        if (l_en) begin
            chk({l_name, "_out"}, {24'd0, out_port}, {24'd0, l_out});
            chk({l_name, "_busy"}, {31'd0, busy}, {31'd0, l_busy});
            if (l_rd_en) chk({l_name, "_rd"}, readdata, l_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Post a literal check for the coming negedge; consumes no clock edge.
    task automatic lit(input string n, input logic [7:0] o, input logic b,
                       input logic rd_en, input logic [2:0] a, input logic [31:0] v);
        l_name = n; l_out = o; l_busy = b; l_rd_en = rd_en; l_rd = v;
        if (rd_en) begin
            chipselect = 1'b0; write_n = 1'b1; address = a;
        end
        l_en = 1'b1;
        @(negedge clk);
        #1;
        l_en = 1'b0; l_rd_en = 1'b0;
    endtask

    initial begin
        int r;
        // Reset state
        lit("rst_hold", RV, 1'b0, 1'b1, 3'd1, 32'd4);
        reset_n = 1'b1;
        step();
        lit("rst_len", RV, 1'b0, 1'b1, 3'd1, 32'd4);
        lit("rst_status", RV, 1'b0, 1'b1, 3'd2, 32'd0);

        // DATA / OUTSET / OUTCLR
        wr(3'd0, 32'h0F);  lit("data", 8'h0F, 1'b0, 1'b0, 3'd0, 32'd0);
        wr(3'd4, 32'h30);  lit("outset", 8'h3F, 1'b0, 1'b0, 3'd0, 32'd0);
        wr(3'd5, 32'h01);  lit("outclr", 8'h3E, 1'b0, 1'b1, 3'd0, 32'h3E);
        lit("rd_outset", 8'h3E, 1'b0, 1'b1, 3'd4, 32'd0);
        lit("rd_outclr", 8'h3E, 1'b0, 1'b1, 3'd5, 32'd0);
        lit("rd_pulse", 8'h3E, 1'b0, 1'b1, 3'd6, 32'd0);

        // Three-cycle pulse
        wr(3'd1, 32'd3); wr(3'd0, 32'd0); wr(3'd6, 32'h02);
        for (int i = 0; i < 5; i++) begin
            lit("pulse3", (i < 3) ? 8'h02 : 8'h00, i < 3, 1'b0, 3'd0, 32'd0);
            step();
        end

        // Zero length behaves as one cycle
        wr(3'd1, 32'd0); wr(3'd6, 32'h80);
        lit("len0_on", 8'h80, 1'b1, 1'b0, 3'd0, 32'd0);
        step();
        lit("len0_off", 8'h00, 1'b0, 1'b0, 3'd0, 32'd0);

        // Overrun on early second PULSE, then cleared by a STATUS write
        wr(3'd1, 32'd5); wr(3'd6, 32'h01);
        step(); step();
        wr(3'd6, 32'h02);
        lit("overrun", 8'h01, 1'b1, 1'b1, 3'd2, 32'd3);
        wr(3'd2, 32'd0);
        lit("ovr_clr", 8'h01, 1'b1, 1'b1, 3'd2, 32'd1);
        step();
        lit("ovr_done", 8'h00, 1'b0, 1'b1, 3'd2, 32'd0);

        // Back-to-back pulse at cnt == 1
        wr(3'd1, 32'd2); wr(3'd6, 32'h04);
        lit("b2b_a0", 8'h04, 1'b1, 1'b0, 3'd0, 32'd0);
        step();
        lit("b2b_a1", 8'h04, 1'b1, 1'b0, 3'd0, 32'd0);
        wr(3'd6, 32'h08);
        lit("b2b_b0", 8'h08, 1'b1, 1'b0, 3'd0, 32'd0);
        step();
        lit("b2b_b1", 8'h08, 1'b1, 1'b0, 3'd0, 32'd0);
        step();
        lit("b2b_end", 8'h00, 1'b0, 1'b1, 3'd2, 32'd0);

        // Reset mid-pulse aborts immediately
        wr(3'd1, 32'd10); wr(3'd6, 32'hFF);
        step(); step(); step();
        reset_n = 1'b0;
        lit("rst_mid", RV, 1'b0, 1'b0, 3'd0, 32'd0);
        reset_n = 1'b1;
        step();
        lit("rst_mid_len", RV, 1'b0, 1'b1, 3'd1, 32'd4);
        lit("rst_mid_status", RV, 1'b0, 1'b1, 3'd2, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 9);
            chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
            case (r)
                0, 1, 2: address = 3'd6;
                3: begin
                    address = 3'd1;
                    writedata = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 4);
                end
                4: address = 3'd0;
                5: address = 3'd4;
                6: address = 3'd5;
                7: address = 3'd2;
                8: address = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd7;
                default: begin
                    write_n = 1'b1;
                    address = 3'($urandom_range(0, 7));
                end
            endcase
            if (n == 400) begin
                chipselect = 1'b0; write_n = 1'b1;
                reset_n = 1'b0;
                #4;
                reset_n = 1'b1;
            end
            step();
        end
        chipselect = 1'b0; write_n = 1'b1;
        repeat (8) step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
